// File: rtl/isqrt_seq_if.sv
// Start/busy job interface for the sequential integer square root.
// The master issues radicands; the slave returns root and remainder.
interface isqrt_seq_if #(
  parameter int WIDTH = 64
);
  logic               start_i;
  logic [WIDTH-1:0]   x_bi;
  logic [WIDTH/2-1:0] y_bo;
  logic [WIDTH/2:0]   rem_bo;
  logic               busy_o;

  modport master (
    output start_i, x_bi,
    input  y_bo, rem_bo, busy_o
  );

  modport slave (
    input  start_i, x_bi,
    output y_bo, rem_bo, busy_o
  );
endinterface

// File: rtl/isqrt_seq.sv
// Sequential floor(sqrt(x)) with remainder, bit-pair restoring method,
// one root bit per clock; result lands WIDTH/2+1 cycles after start.
module isqrt_seq #(
  parameter int WIDTH = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  isqrt_seq_if.slave  bus
);
  localparam int HALF  = WIDTH / 2;
  localparam int CTR_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [WIDTH-1:0] M_INIT   = WIDTH'(1) << (WIDTH - 2);
  localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(HALF - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WORK = 2'd1,
    ST_END  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   x_q, x_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [CTR_W-1:0]   ctr_q, ctr_d;
  logic [HALF-1:0]    yo_q, yo_d;
  logic [HALF:0]      rem_q, rem_d;
  logic               busy_q, busy_d;
  logic [WIDTH-1:0]   b;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      m_q     <= '0;
      ctr_q   <= '0;
      yo_q    <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      m_q     <= m_d;
      ctr_q   <= ctr_d;
      yo_q    <= yo_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    m_d     = m_q;
    ctr_d   = ctr_q;
    yo_d    = yo_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    b       = y_q | m_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          x_d     = bus.x_bi;
          y_d     = '0;
          m_d     = M_INIT;
          ctr_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_WORK;
        end
      end
      ST_WORK: begin
        // Subtraction is only taken when x_q >= b, so it never wraps.
        if (x_q >= b) begin
          x_d = x_q - b;
          y_d = (y_q >> 1) | m_q;
        end else begin
          y_d = y_q >> 1;
        end
        m_d   = m_q >> 2;
        ctr_d = ctr_q + CTR_W'(1);
        if (ctr_q == CTR_LAST) begin
          state_d = ST_END;
        end
      end
      ST_END: begin
        yo_d    = y_q[HALF-1:0];
        rem_d   = x_q[HALF:0];
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.y_bo   = yo_q;
  assign bus.rem_bo = rem_q;
  assign bus.busy_o = busy_q;
endmodule

// File: tb/tb_isqrt_seq.sv
// Scoreboard bench for isqrt_seq: stimulus queues expected root/remainder,
// a monitor checks them when busy_o falls.
module tb_isqrt_seq;
  localparam int WIDTH = 64;
  localparam int LAT   = WIDTH / 2 + 1;

  typedef struct {
    logic [31:0] y;
    logic [32:0] rem;
  } exp_t;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;
  int   falls;
  int   exp_falls;
  int   busy_cnt;
  logic prev_busy;
  exp_t sb[$];

  isqrt_seq_if #(.WIDTH(WIDTH)) bus ();

  isqrt_seq #(.WIDTH(WIDTH)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compares on every busy_o falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_busy = 1'b0;
      busy_cnt  = 0;
    end else begin
      if (bus.busy_o) busy_cnt++;
      if (prev_busy && !bus.busy_o) begin
        exp_t e;
        falls++;
        tests_run++;
        if (sb.size() == 0) begin
          tests_failed++;
          $display("FAIL unexpected_result: got y=%h rem=%h, required no result", bus.y_bo, bus.rem_bo);
        end else begin
          e = sb.pop_front();
          if (bus.y_bo !== e.y || bus.rem_bo !== e.rem) begin
            tests_failed++;
            $display("FAIL result: got y=%h rem=%h, required y=%h rem=%h", bus.y_bo, bus.rem_bo, e.y, e.rem);
          end else begin
            $display("[TB] ok y=%h rem=%h", bus.y_bo, bus.rem_bo);
          end
          tests_run++;
          if (busy_cnt != LAT) begin
            tests_failed++;
            $display("FAIL busy_len: got %0d cycles, required %0d", busy_cnt, LAT);
          end
        end
        busy_cnt = 0;
      end
      prev_busy = bus.busy_o;
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    tests_run++;
    if (got !== req) begin
      tests_failed++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy_o === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("wait_idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic issue(input logic [63:0] x, input logic [31:0] ey, input logic [32:0] erem, input bit expect_it);
    exp_t e;
    wait_idle();
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.x_bi    = x;
    if (expect_it) begin
      e.y = ey;
      e.rem = erem;
      sb.push_back(e);
      exp_falls++;
    end
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.x_bi    = '0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.busy_o === 1'b1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("drain_timeout", 64'd1, 64'd0);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [63:0] r;
    logic [63:0] xv;
    tests_run = 0; tests_failed = 0; falls = 0; exp_falls = 0;
    busy_cnt = 0; prev_busy = 1'b0;
    rst_n = 1'b0;
    bus.start_i = 1'b1;
    bus.x_bi = 64'd5;

    // Reset held with start high: nothing may happen.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_busy", {63'd0, bus.busy_o}, 64'd0);
      check("reset_y", {32'd0, bus.y_bo}, 64'd0);
      check("reset_rem", {31'd0, bus.rem_bo}, 64'd0);
    end
    bus.start_i = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    issue(64'd0, 32'd0, 33'd0, 1'b1);
    issue(64'd144, 32'd12, 33'd0, 1'b1);
    issue(64'd150, 32'd12, 33'd6, 1'b1);
    issue(64'd1, 32'd1, 33'd0, 1'b1);
    issue(64'd3, 32'd1, 33'd2, 1'b1);
    issue(64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF, 33'd0, 1'b1);
    issue(64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 33'h1_FFFF_FFFE, 1'b1);
    issue(64'd10001, 32'd100, 33'd1, 1'b1);
    drain();

    // Start while busy is ignored.
    issue(64'd150, 32'd12, 33'd6, 1'b1);
    repeat (8) @(negedge clk);
    bus.start_i = 1'b1;
    bus.x_bi = 64'd144;
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.x_bi = '0;
    drain();
    repeat (40) @(negedge clk);
    check("single_fall", 64'(falls), 64'(exp_falls));

    // Back-to-back with start held: one idle cycle between jobs.
    wait_idle();
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.x_bi = 64'd144;
    sb.push_back('{y: 32'd12, rem: 33'd0});
    exp_falls++;
    @(negedge clk);
    bus.x_bi = 64'd150;
    sb.push_back('{y: 32'd12, rem: 33'd6});
    exp_falls++;
    wait_idle();
    check("b2b_gap_idle", {63'd0, bus.busy_o}, 64'd0);
    @(negedge clk);
    check("b2b_reaccept", {63'd0, bus.busy_o}, 64'd1);
    bus.start_i = 1'b0;
    bus.x_bi = '0;
    drain();

    // Async reset mid-job, between clock edges.
    issue(64'd150, 32'd0, 33'd0, 1'b0);
    repeat (13) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", {63'd0, bus.busy_o}, 64'd0);
    check("async_rst_y", {32'd0, bus.y_bo}, 64'd0);
    check("async_rst_rem", {31'd0, bus.rem_bo}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_idle", {63'd0, bus.busy_o}, 64'd0);
    issue(64'd10000, 32'd100, 33'd0, 1'b1);
    drain();

    // Squared-plus-offset vectors: y=a, rem=r for r in [0, 2a].
    for (int k = 0; k < 30; k++) begin
      a = $urandom;
      if (k == 0) a = 32'hFFFF_FFFF;
      r = {$urandom, $urandom} % (64'(a) * 2 + 1);
      if (k % 3 == 0) r = 64'd0;
      xv = 64'(a) * 64'(a) + r;
      issue(xv, a, r[32:0], 1'b1);
    end
    drain();
    check("fall_count", 64'(falls), 64'(exp_falls));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/isqrt_seq.md
# isqrt_seq

Sequential integer square-root unit that sits directly downstream of the shift-add multiplier and consumes its 64-bit product. It uses the same start/busy handshake as the multiplier. It computes floor(sqrt(x)) and the remainder with the bit-pair restoring algorithm, retiring one result bit per clock. A result is produced WIDTH/2+1 cycles after start is accepted.

## Interface
- WIDTH, 64: radicand width. Must be even and ≥ 4. Default matches the multiplier output.
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, asynchronous, active-low. Asserts immediately; deassertion is synchronised externally.
- start_i  input  1  request. Sampled only in IDLE.
- x_bi  input  WIDTH  radicand. Captured on the accepting edge, so it may change afterwards.
- y_bo  output  WIDTH/2  root, floor(sqrt(x)). Registered, holds until the next END.
- rem_bo  output  WIDTH/2+1  remainder, x − y². Registered, holds until the next END.
- busy_o  output  1  high from the accepting edge until END.

## Operation
- Internal registers:
  - state: IDLE, WORK, END
  - x_r: WIDTH bits, running remainder
  - y_r: WIDTH bits, partial root
  - m_r: WIDTH bits, one-hot probe
  - ctr: $clog2(WIDTH/2) bits
- Reset (rst_i low, asynchronous):
  - state=IDLE
  - y_bo=0, rem_bo=0, busy_o=0
  - x_r, y_r, m_r and ctr cleared
- IDLE:
  - start_i=1 → x_r=x_bi, y_r=0, m_r=1<<(WIDTH−2), ctr=0, busy_o=1, state=WORK.
  - start_i=0 → no change.
- WORK, one iteration per cycle:
  - b = y_r | m_r, computed combinationally, WIDTH bits.
  - If x_r ≥ b (unsigned): x_r −= b and y_r = (y_r>>1) | m_r. Otherwise only y_r = y_r>>1.
  - m_r = m_r>>2; ctr += 1.
  - When ctr == WIDTH/2−1 on this edge, go to END.
- END:
  - y_bo = y_r[WIDTH/2−1:0]; rem_bo = x_r[WIDTH/2:0].
  - busy_o=0; state=IDLE.
- Arithmetic:
  - All comparisons and subtractions are unsigned at WIDTH bits; no overflow is possible, since b ≤ x_r whenever the subtraction is taken.
  - rem ≤ 2·y, so it fits in WIDTH/2+1 bits.
- Illegal or unused state encoding → IDLE on the next edge; outputs unchanged.
- start_i while busy (WORK or END) is ignored. It is not queued.

## Timing
- Accept edge T0 (IDLE, start_i=1): busy_o rises after T0.
- WORK occupies edges T0+1 … T0+WIDTH/2.
- END edge is T0+WIDTH/2+1: y_bo and rem_bo update and busy_o falls on this same edge.
- Latency: WIDTH/2+1 cycles (33 for WIDTH=64). busy_o is high for exactly WIDTH/2+1 cycles.
- Back-to-back: a start_i held high through END is accepted at edge T0+WIDTH/2+2, giving one idle cycle with busy_o=0 between jobs.
- Chaining with the multiplier: its busy_o falling edge marks its y_bo valid. A one-cycle pulse on start_i in the next cycle captures that value.
- Reset mid-operation: outputs go to 0 immediately; the job in flight is discarded. After release, the block waits in IDLE for a new start_i.

## Test plan
- Reset: hold rst_i=0 with start_i=1 → y_bo=0, rem_bo=0, busy_o=0, with no transition. Release, then pulse start with x=0 → after 33 cycles y=0, rem=0.
- Perfect and non-perfect squares:
  - x=144 → y=12, rem=0
  - x=150 → y=12, rem=6
  - x=1 → y=1, rem=0
  - x=3 → y=1, rem=2
  - busy_o must be high for exactly 33 cycles in each case.
- Extremes:
  - x=0xFFFF_FFFE_0000_0001 → y=0xFFFF_FFFF, rem=0
  - x=0xFFFF_FFFF_FFFF_FFFF → y=0xFFFF_FFFF, rem=0x1_FFFF_FFFE
- Busy protection: start with x=150, then pulse start_i with x=144 at cycle 10 → the second request is ignored; result is y=12, rem=6; busy_o falls exactly once.
- Async reset mid-job: drop rst_i at cycle 15 between clock edges → outputs clear without waiting for an edge. A subsequent x=10000 gives y=100, rem=0 with normal latency.
- Random plus chained: feed 1000 random 64-bit values, including mult outputs a² for random a → check y²≤x<(y+1)², rem=x−y², and y=a for squared inputs.
